seven_seg_capture: RTL and testbench

SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

---
 rtl/seven_seg_capture_if.sv | 25 ++
 rtl/seven_seg_capture.sv | 117 +++++++++++
 tb/tb_seven_seg_capture.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_capture_if.sv
// Signal bundle between a multiplexed seven-segment display bus and its capture block.
// The display side drives seg/en; the capture side returns the decoded numbers and pulses.
interface seven_seg_capture_if #(
  parameter int NUM_WIDTH = 13
);
  logic [6:0]           seg_in;
  logic [7:0]           en_in;
  logic [NUM_WIDTH-1:0] NumberA;
  logic [NUM_WIDTH-1:0] NumberB;
  logic                 ValidA;
  logic                 ValidB;
  logic                 UpdA;
  logic                 UpdB;
  logic                 BusErr;

  modport master (
    output seg_in, en_in,
    input  NumberA, NumberB, ValidA, ValidB, UpdA, UpdB, BusErr
  );

  modport slave (
    input  seg_in, en_in,
    output NumberA, NumberB, ValidA, ValidB, UpdA, UpdB, BusErr
  );
endinterface

// File: rtl/seven_seg_capture.sv
// Snoops a scanned, active-low seven-segment display bus and rebuilds the two
// four-digit decimal numbers (A on enables 3..0, B on enables 7..4).
module seven_seg_capture #(
  parameter int NUM_WIDTH     = 13,
  parameter int STABLE_CYCLES = 16
) (
  input logic Clk,
  input logic Rst,
  seven_seg_capture_if.slave bus
);

  localparam logic [7:0] LastCount   = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] AcceptCount = 8'(STABLE_CYCLES - 2);

  logic [6:0]           segReg;
  logic [7:0]           enReg;
  logic [14:0]          prevSample;
  logic [7:0]           stableCnt;
  logic [3:0]           slot [8];
  logic [7:0]           seen;
  logic [NUM_WIDTH-1:0] numA, numB;
  logic                 validA, validB, updA, updB, busErr;

  logic [14:0] sample;
  logic        oneHot, multiEn, prevMulti, stable, accept;
  logic [2:0]  idx;
  logic [3:0]  digit;
  logic        completeA, completeB;
  logic [7:0]  acceptMask, clearMask;

  function automatic logic [3:0] decodeSeg(input logic [6:0] s);
    case (s)
      7'h01:   return 4'd0;
      7'h4F:   return 4'd1;
      7'h12:   return 4'd2;
      7'h06:   return 4'd3;
      7'h4C:   return 4'd4;
      7'h24:   return 4'd5;
      7'h20:   return 4'd6;
      7'h0F:   return 4'd7;
      7'h00:   return 4'd8;
      7'h04:   return 4'd9;
      default: return 4'hF;
    endcase
  endfunction

  // Returns {valid, number}; an undecodable digit or a value too wide for NUM_WIDTH gives all ones.
  function automatic logic [NUM_WIDTH:0] buildNumber(input logic [3:0] d3, input logic [3:0] d2,
                                                     input logic [3:0] d1, input logic [3:0] d0);
    logic [13:0] sum;
    logic        ok;
    sum = 14'(d3) * 14'd1000 + 14'(d2) * 14'd100 + 14'(d1) * 14'd10 + 14'(d0);
    ok  = (d3 <= 4'd9) && (d2 <= 4'd9) && (d1 <= 4'd9) && (d0 <= 4'd9);
    if ((32'(sum) >> NUM_WIDTH) != 32'd0) ok = 1'b0;
    if (ok) return {1'b1, NUM_WIDTH'(sum)};
    return {1'b0, {NUM_WIDTH{1'b1}}};
  endfunction

  always_comb begin
    sample    = {enReg, segReg};
    oneHot    = ($countones(~enReg) == 1);
    multiEn   = ($countones(~enReg) > 1);
    prevMulti = ($countones(~prevSample[14:7]) > 1);
    stable    = oneHot && (sample == prevSample);
    // Counter saturates at LastCount, so a held digit is taken only once.
    accept    = stable && (stableCnt == AcceptCount);
    idx       = '0;
    for (int i = 0; i < 8; i++) begin
      if (!enReg[i]) idx = 3'(i);
    end
    digit      = decodeSeg(segReg);
    completeA  = &seen[3:0];
    completeB  = &seen[7:4];
    acceptMask = accept ? (8'd1 << idx) : 8'd0;
    clearMask  = {{4{completeB}}, {4{completeA}}};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      segReg     <= '1;
      enReg      <= '1;
      prevSample <= '1;
      stableCnt  <= '0;
      seen       <= '0;
      for (int i = 0; i < 8; i++) slot[i] <= 4'hF;
      numA       <= '0;
      numB       <= '0;
      validA     <= 1'b0;
      validB     <= 1'b0;
      updA       <= 1'b0;
      updB       <= 1'b0;
      busErr     <= 1'b0;
    end else begin
      segReg     <= bus.seg_in;
      enReg      <= bus.en_in;
      prevSample <= sample;
      if (!stable) stableCnt <= '0;
      else if (stableCnt != LastCount) stableCnt <= stableCnt + 8'd1;
      if (accept) slot[idx] <= digit;
      seen   <= (seen & ~clearMask) | acceptMask;
      updA   <= completeA;
      updB   <= completeB;
      busErr <= multiEn && !prevMulti;
      if (completeA) {validA, numA} <= buildNumber(slot[3], slot[2], slot[1], slot[0]);
      if (completeB) {validB, numB} <= buildNumber(slot[7], slot[6], slot[5], slot[4]);
    end
  end

  assign bus.NumberA = numA;
  assign bus.NumberB = numB;
  assign bus.ValidA  = validA;
  assign bus.ValidB  = validB;
  assign bus.UpdA    = updA;
  assign bus.UpdB    = updB;
  assign bus.BusErr  = busErr;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: a hold-level display model queues expected number
// updates and bus errors; a negedge monitor pops them whenever the DUT pulses.
module tb_seven_seg_capture;
  // 9999 needs 14 bits, so the bench uses 14 to see full-range values as valid.
  localparam int NW     = 14;
  localparam int STABLE = 16;

  typedef struct packed {
    logic          valid;
    logic [NW-1:0] num;
  } res_t;

  logic Clk;
  logic Rst;
  seven_seg_capture_if #(.NUM_WIDTH(NW)) bus ();

  seven_seg_capture #(.NUM_WIDTH(NW), .STABLE_CYCLES(STABLE)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int total = 0;
  int bad   = 0;

  res_t qA[$];
  res_t qB[$];
  bit   qErr[$];

  logic [6:0]  segTab [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};
  int          mSlot [8];
  bit   [7:0]  mSeen;
  bit          mPrevMulti;
  logic [14:0] mPrevSample;
  res_t        lastA, lastB;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic int segToDigit(input logic [6:0] s);
    for (int d = 0; d < 10; d++) if (segTab[d] == s) return d;
    return 15;
  endfunction

  function automatic res_t makeResult(input int d3, input int d2, input int d1, input int d0);
    res_t   r;
    longint v;
    bit     ok;
    v  = d3 * 1000 + d2 * 100 + d1 * 10 + d0;
    ok = (d3 < 10) && (d2 < 10) && (d1 < 10) && (d0 < 10) && (v < (longint'(1) << NW));
    r.valid = ok;
    r.num   = ok ? NW'(v) : '1;
    return r;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 8; i++) mSlot[i] = 15;
    mSeen       = '0;
    mPrevMulti  = 1'b0;
    mPrevSample = '1;
    lastA       = '0;
    lastB       = '0;
  endtask

  // Drive one bus value for n cycles; a one-hot value held for STABLE or more samples is a digit.
  task automatic hold(input logic [7:0] en, input logic [6:0] seg, input int n);
    int zeros, idx;
    zeros = 0;
    idx   = 0;
    for (int i = 0; i < 8; i++) if (!en[i]) begin zeros++; idx = i; end
    if (zeros >= 2 && !mPrevMulti) qErr.push_back(1'b1);
    mPrevMulti  = (zeros >= 2);
    mPrevSample = {en, seg};
    if (zeros == 1 && n >= STABLE) begin
      mSlot[idx]  = segToDigit(seg);
      mSeen[idx]  = 1'b1;
      if (mSeen[3:0] == 4'hF) begin
        lastA = makeResult(mSlot[3], mSlot[2], mSlot[1], mSlot[0]);
        qA.push_back(lastA);
        mSeen[3:0] = '0;
      end
      if (mSeen[7:4] == 4'hF) begin
        lastB = makeResult(mSlot[7], mSlot[6], mSlot[5], mSlot[4]);
        qB.push_back(lastB);
        mSeen[7:4] = '0;
      end
    end
    bus.en_in  = en;
    bus.seg_in = seg;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic scanA(input int d3, input int d2, input int d1, input int d0, input int n);
    hold(8'hFE, segTab[d0], n);
    hold(8'hFD, segTab[d1], n);
    hold(8'hFB, segTab[d2], n);
    hold(8'hF7, segTab[d3], n);
  endtask

  task automatic scanB(input int d3, input int d2, input int d1, input int d0, input int n);
    hold(8'hEF, segTab[d0], n);
    hold(8'hDF, segTab[d1], n);
    hold(8'hBF, segTab[d2], n);
    hold(8'h7F, segTab[d3], n);
  endtask

  task automatic doReset();
    Rst        = 1'b1;
    bus.en_in  = 8'hFF;
    bus.seg_in = 7'h7F;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    modelReset();
    check("reset NumberA", 32'(bus.NumberA), 0);
    check("reset NumberB", 32'(bus.NumberB), 0);
    check("reset ValidA", 32'(bus.ValidA), 0);
    check("reset ValidB", 32'(bus.ValidB), 0);
    check("reset pulses", 32'({bus.UpdA, bus.UpdB, bus.BusErr}), 0);
  endtask

  task automatic drainCheck(input string tag);
    hold(8'hFF, 7'h7F, 4);
    check({tag, " pending UpdA"}, 32'(qA.size()), 0);
    check({tag, " pending UpdB"}, 32'(qB.size()), 0);
    check({tag, " pending BusErr"}, 32'(qErr.size()), 0);
    check({tag, " NumberA"}, 32'(bus.NumberA), 32'(lastA.num));
    check({tag, " ValidA"}, 32'(bus.ValidA), 32'(lastA.valid));
    check({tag, " NumberB"}, 32'(bus.NumberB), 32'(lastB.num));
    check({tag, " ValidB"}, 32'(bus.ValidB), 32'(lastB.valid));
  endtask

  always @(negedge Clk) begin
    res_t e;
    if (Rst) begin
      check("pulse during reset", 32'({bus.UpdA, bus.UpdB, bus.BusErr}), 0);
    end else begin
      if (bus.UpdA) begin
        if (qA.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected UpdA: got NumberA=%0d, want no update", bus.NumberA);
        end else begin
          e = qA.pop_front();
          check("UpdA NumberA", 32'(bus.NumberA), 32'(e.num));
          check("UpdA ValidA", 32'(bus.ValidA), 32'(e.valid));
        end
      end
      if (bus.UpdB) begin
        if (qB.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected UpdB: got NumberB=%0d, want no update", bus.NumberB);
        end else begin
          e = qB.pop_front();
          check("UpdB NumberB", 32'(bus.NumberB), 32'(e.num));
          check("UpdB ValidB", 32'(bus.ValidB), 32'(e.valid));
        end
      end
      if (bus.BusErr) begin
        if (qErr.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected BusErr: got 1, want 0");
        end else begin
          void'(qErr.pop_front());
          total++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] en;
    logic [6:0] seg;
    int r, a, b;

    Rst        = 1'b1;
    bus.en_in  = 8'hFF;
    bus.seg_in = 7'h7F;
    modelReset();
    @(posedge Clk);
    #1;
    doReset();

    scanA(4, 3, 2, 1, 20);
    drainCheck("scan 4321");
    check("scan 4321 value", 32'(bus.NumberA), 4321);

    hold(8'hFE, segTab[5], 10);
    scanA(7, 7, 7, 7, 20);
    drainCheck("short hold");

    for (int loop = 0; loop < 2; loop++) begin
      scanA(0, 0, 0, 0, 20);
      scanB(9, 9, 9, 9, 20);
      drainCheck("A0000 B9999");
    end
    check("B9999 value", 32'(bus.NumberB), 9999);

    hold(8'hFE, segTab[1], 20);
    hold(8'hFD, segTab[2], 20);
    hold(8'hFB, 7'h7F, 20);
    hold(8'hF7, segTab[3], 20);
    drainCheck("blank digit");

    hold(8'hFE, segTab[6], 20);
    hold(8'hFD, segTab[5], 20);
    hold(8'hFC, segTab[8], 5);
    hold(8'hFB, segTab[4], 20);
    hold(8'hF7, segTab[2], 20);
    drainCheck("multi-enable");

    hold(8'hFE, segTab[1], 20);
    hold(8'hFD, segTab[2], 20);
    hold(8'hFB, segTab[3], 20);
    doReset();
    hold(8'hF7, segTab[8], 20);
    hold(8'hFB, segTab[7], 20);
    hold(8'hFD, segTab[6], 20);
    hold(8'hFE, segTab[5], 20);
    drainCheck("reset mid-frame");
    check("reset mid-frame value", 32'(bus.NumberA), 8765);

    for (int k = 0; k < 300; k++) begin
      do begin
        r = $urandom_range(0, 99);
        if (r < 75) en = ~(8'd1 << $urandom_range(0, 7));
        else if (r < 85) en = 8'hFF;
        else begin
          a  = $urandom_range(0, 7);
          b  = (a + $urandom_range(1, 7)) % 8;
          en = ~((8'd1 << a) | (8'd1 << b));
        end
        seg = ($urandom_range(0, 9) < 8) ? segTab[$urandom_range(0, 9)] : 7'($urandom);
      end while ({en, seg} == mPrevSample);
      hold(en, seg, $urandom_range(8, 24));
    end
    drainCheck("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
